// File: rtl/mycpu_wb.sv
// Write-back / memory stage: accepts one EX result at a time, runs the data-memory
// handshake for loads and stores, and drives a single-cycle register-file write.
module mycpu_wb #(
    parameter logic CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_PC,
    input  logic [31:0] in_aluResult,
    input  logic [31:0] in_storeData,
    input  logic [4:0]  in_targetReg,
    input  logic        in_C3,
    input  logic        in_C5,
    input  logic        in_C6,
    output logic        data_req,
    output logic        data_wr,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        wen,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        pendValid,
    output logic [4:0]  pendAddr,
    output logic        excFlag,
    output logic [31:0] badAddr,
    output logic [31:0] debug_wb_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [4:0]  tgt_q, tgt_d;
    logic        c3_q, c3_d;
    logic        c5_q, c5_d;
    logic        c6_q, c6_d;
    logic        wen_q, wen_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wbpc_q, wbpc_d;
    logic        pend_q, pend_d;
    logic [4:0]  pend_addr_q, pend_addr_d;
    logic        exc_q, exc_d;
    logic [31:0] bad_q, bad_d;

    logic        accept_s;
    logic        is_mem_s;
    logic        misal_s;

    // Next-state, operand capture and write-back decisions.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        tgt_d       = tgt_q;
        c3_d        = c3_q;
        c5_d        = c5_q;
        c6_d        = c6_q;
        wen_d       = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wbpc_d      = wbpc_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        exc_d       = exc_q;
        bad_d       = bad_q;

        in_ready = rst & (state_q == S_IDLE);
        accept_s = in_valid & in_ready;
        is_mem_s = in_C3 | in_C6;
        misal_s  = CHECK_ALIGN & is_mem_s & (in_aluResult[1:0] != 2'b00);

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    pc_d    = in_PC;
                    addr_d  = in_aluResult;
                    sdata_d = in_storeData;
                    tgt_d   = in_targetReg;
                    c3_d    = in_C3;
                    c5_d    = in_C5;
                    c6_d    = in_C6;
                    if (!is_mem_s) begin
                        if (in_C5 && (in_targetReg != 5'd0)) begin
                            wen_d   = 1'b1;
                            waddr_d = in_targetReg;
                            wdata_d = in_aluResult;
                            wbpc_d  = in_PC;
                        end else begin
                            wen_d = 1'b0;
                        end
                    end else if (misal_s) begin
                        // Only the first trapped address is kept; the flag is sticky.
                        exc_d = 1'b1;
                        bad_d = exc_q ? bad_q : in_aluResult;
                    end else begin
                        state_d = S_REQ;
                        if (in_C3 && !in_C6) begin
                            pend_d      = 1'b1;
                            pend_addr_d = in_targetReg;
                        end else begin
                            pend_d = pend_q;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (data_addr_ok) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_d = S_IDLE;
                    if (c3_q && !c6_q) begin
                        pend_d      = 1'b0;
                        pend_addr_d = 5'd0;
                        if (c5_q && (tgt_q != 5'd0)) begin
                            wen_d   = 1'b1;
                            waddr_d = tgt_q;
                            wdata_d = data_rdata;
                            wbpc_d  = pc_q;
                        end else begin
                            wen_d = 1'b0;
                        end
                    end else begin
                        pend_d = pend_q;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= 32'd0;
            addr_q      <= 32'd0;
            sdata_q     <= 32'd0;
            tgt_q       <= 5'd0;
            c3_q        <= 1'b0;
            c5_q        <= 1'b0;
            c6_q        <= 1'b0;
            wen_q       <= 1'b0;
            waddr_q     <= 5'd0;
            wdata_q     <= 32'd0;
            wbpc_q      <= 32'd0;
            pend_q      <= 1'b0;
            pend_addr_q <= 5'd0;
            exc_q       <= 1'b0;
            bad_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            tgt_q       <= tgt_d;
            c3_q        <= c3_d;
            c5_q        <= c5_d;
            c6_q        <= c6_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wbpc_q      <= wbpc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            exc_q       <= exc_d;
            bad_q       <= bad_d;
        end
    end

    assign data_req    = (state_q == S_REQ);
    assign data_wr     = c6_q;
    assign data_addr   = {addr_q[31:2], 2'b00};
    assign data_wdata  = sdata_q;
    assign wen         = wen_q;
    assign waddr       = waddr_q;
    assign wdata       = wdata_q;
    assign debug_wb_pc = wbpc_q;
    assign pendValid   = pend_q;
    assign pendAddr    = pend_addr_q;
    assign excFlag     = exc_q;
    assign badAddr     = bad_q;

endmodule

// File: doc/mycpu_wb.md
MYCPU_WB -- requirements
Module: myCPU_WB

Interface
REQ-001 Parameter: CHECK_ALIGN, default 1, meaning 1 = misaligned word accesses are trapped, 0 = the low two address bits are ignored.
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 Ports are listed below as name, direction, width, meaning.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous reset, active low.
REQ-006 in_valid  in  1  upstream (EX) holds a valid instruction result.
REQ-007 in_ready  out  1  block can accept an instruction this cycle.
REQ-008 in_PC  in  32  PC of the offered instruction.
REQ-009 in_aluResult  in  32  ALU result; this is the memory address for loads and stores.
REQ-010 in_storeData  in  32  rt contents for a store.
REQ-011 in_targetReg  in  5  destination register.
REQ-012 in_C3  in  1  1 = load (memory to register).
REQ-013 in_C5  in  1  1 = the register file write is enabled.
REQ-014 in_C6  in  1  1 = store (memory write).
REQ-015 data_req  out  1  data-memory request.
REQ-016 data_wr  out  1  1 = write request, 0 = read request.
REQ-017 data_addr  out  32  word address.
REQ-018 data_wdata  out  32  store data.
REQ-019 data_addr_ok  in  1  request accepted by memory.
REQ-020 data_data_ok  in  1  response valid.
REQ-021 data_rdata  in  32  load data.
REQ-022 wen  out  1  register-file write enable, driven to the ID stage.
REQ-023 waddr  out  5  register-file write address.
REQ-024 wdata  out  32  register-file write data.
REQ-025 pendValid  out  1  a load is outstanding.
REQ-026 pendAddr  out  5  destination register of the outstanding load, used by ID for interlock.
REQ-027 excFlag  out  1  sticky flag for a misaligned access.
REQ-028 badAddr  out  32  address of the first misaligned access.
REQ-029 debug_wb_pc  out  32  PC of the instruction whose write is on wen/waddr/wdata.

Function
REQ-030 States SHALL be IDLE, REQ and WAIT; in_ready SHALL be 1 only in IDLE.
REQ-031 An instruction SHALL be accepted when in_valid & in_ready; the PC, target register, C3/C5/C6, address and store data are latched on acceptance.
REQ-032 Accepted non-memory instruction with C5=1 and target register ≠ 0: the next cycle SHALL drive wen=1 with waddr=target, wdata=aluResult and debug_wb_pc=PC; state stays IDLE.
REQ-033 Accepted memory instruction (C3|C6) that is aligned, or any memory instruction when CHECK_ALIGN=0: the state SHALL go to REQ.
REQ-034 Accepted memory instruction with CHECK_ALIGN=1 and aluResult[1:0]≠0: no request SHALL be issued and no register write SHALL occur.
REQ-035 In that misaligned case, excFlag SHALL be set, and badAddr SHALL capture the address only if excFlag was previously 0; state stays IDLE.
REQ-036 In REQ, data_req SHALL be 1, with data_wr=C6, data_addr={addr[31:2],2'b00} and data_wdata=storeData, all held stable until data_addr_ok.
REQ-037 On data_addr_ok in REQ, the state SHALL go to WAIT and data_req SHALL go to 0 the next cycle.
REQ-038 In WAIT, data_data_ok SHALL complete the access and return the state to IDLE.
REQ-039 On completion of a load with target ≠ 0 and C5=1: the next cycle SHALL drive wen=1, waddr=target and wdata=data_rdata as sampled with data_data_ok.
REQ-040 On completion of a store: no register write SHALL occur.
REQ-041 data_data_ok arriving in IDLE or REQ SHALL be ignored.
REQ-042 wen SHALL be a single-cycle registered pulse; wen=0 SHALL always hold for target register 0.
REQ-043 pendValid SHALL be 1 from the cycle after a load is accepted until the cycle its wen pulse is driven, with pendAddr = the load's target register; otherwise pendValid=0 and pendAddr=0.
REQ-044 Latency: non-memory instruction, wen one cycle after acceptance; load, wen one cycle after data_data_ok.
REQ-045 Minimum load latency SHALL be 3 cycles from acceptance: REQ, then WAIT, then write.
REQ-046 Back-to-back: in IDLE a new instruction SHALL be accepted in the same cycle that the previous write's wen pulse is driven.

Reset
REQ-047 When rst=0 at a clock edge: state=IDLE, data_req=0, wen=0, waddr=0, wdata=0, pendValid=0, pendAddr=0, excFlag=0, badAddr=0, debug_wb_pc=0.
REQ-048 While rst=0, in_ready SHALL be 0.
REQ-049 Reset in REQ or WAIT SHALL discard the in-flight access; a data_data_ok after reset SHALL produce no write.

Verification
REQ-050 addu result 0x12345678 to $5, accepted at cycle 0 -> wen=1, waddr=5, wdata=0x12345678 at cycle 1; in_ready stays 1.
REQ-051 lw to $8, addr 0x100; addr_ok at cycle 2, data_ok at cycle 4 with rdata 0xDEADBEEF -> wen/waddr 8/wdata 0xDEADBEEF at cycle 5; pendValid=1 for cycles 1-4; in_ready=0 for cycles 1-4.
REQ-052 sw addr 0x204, data 0xA5A5A5A5 -> data_req=1, data_wr=1, addr 0x204 held until addr_ok; no wen.
REQ-053 lw addr 0x102 with CHECK_ALIGN=1 -> no data_req, excFlag=1, badAddr=0x102; a later sw at 0x301 leaves badAddr=0x102.
REQ-054 addiu to $0 -> wen stays 0; stray data_ok in IDLE -> no wen.
REQ-055 rst=0 asserted during WAIT, then data_ok next cycle -> state IDLE, wen never 1, pendValid=0.
